// File: rtl/mode_sequencer.sv
// mode_sequencer -- display mode and field-edit sequencer for a small BCD display.
//
// A btn_mode press advances the display mode. A btn_edit press steps through
// editing the left (hi) and right (lo) fields; leaving the lo field pulses
// commit. The selected mode's fields are shown as four BCD digits, saturated
// at 99. The field being edited blinks at the tick2hz rate. After TIMEOUT_S
// idle seconds the block returns to mode 0 and abandons any edit.
//
// Optional feature: define ALERT_BLINK_EN to make led flash at the tick2hz
// rate while any alert is active. Without it, led is the steady OR of alert.
//
// Parameters:
//   N_MODES   number of display modes (2..8)
//   TIMEOUT_S idle seconds before auto-return to mode 0 (0 disables)
//   FIELD_W   width of each per-mode field value
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   tick1hz, tick2hz    one-cycle time-base pulses
//   btn_mode, btn_edit  debounced button levels
//   field_hi, field_lo  packed per-mode fields, mode m at [m*FIELD_W +: FIELD_W]
//   alert               per-mode alert requests
//   mode                current mode index
//   edit_field          00 none, 01 hi field, 10 lo field
//   commit              one-cycle pulse when an edit is committed
//   digit3..digit0      BCD digits left to right, 15 = blank
//   led                 alert indicator
module mode_sequencer #(
    parameter int N_MODES   = 4,
    parameter int TIMEOUT_S = 30,
    parameter int FIELD_W   = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick1hz,
    input  logic                         tick2hz,
    input  logic                         btn_mode,
    input  logic                         btn_edit,
    input  logic [N_MODES*FIELD_W-1:0]   field_hi,
    input  logic [N_MODES*FIELD_W-1:0]   field_lo,
    input  logic [N_MODES-1:0]           alert,
    output logic [$clog2(N_MODES)-1:0]   mode,
    output logic [1:0]                   edit_field,
    output logic                         commit,
    output logic [3:0]                   digit3,
    output logic [3:0]                   digit2,
    output logic [3:0]                   digit1,
    output logic [3:0]                   digit0,
    output logic                         led
);

    localparam int MODE_W = $clog2(N_MODES);
    // With the timeout disabled the counter only needs to saturate somewhere.
    localparam int CNT_W  = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 8;

    localparam logic [MODE_W-1:0] MODE_LAST   = MODE_W'(N_MODES - 1);
    localparam logic [CNT_W-1:0]  CNT_TO_LAST = CNT_W'((TIMEOUT_S > 0) ? (TIMEOUT_S - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    // Encoding doubles as the edit_field output code.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EDIT_HI = 2'b01,
        ST_EDIT_LO = 2'b10
    } edit_state_t;

    edit_state_t         state_r;
    edit_state_t         state_nxt_s;
    logic [MODE_W-1:0]   mode_r;
    logic [MODE_W-1:0]   mode_nxt_s;
    logic                commit_r;
    logic                commit_nxt_s;
    logic                mode_prev_r;
    logic                edit_prev_r;
    logic                blink_r;
    logic [CNT_W-1:0]    idle_cnt_r;
    logic [3:0]          digit3_r, digit2_r, digit1_r, digit0_r;
    logic                led_r;
    logic                led_nxt_s;

    logic                mode_edge_s;
    logic                edit_edge_s;
    logic                any_edge_s;
    logic                timeout_s;
    logic                entry_s;
    logic [FIELD_W-1:0]  hi_val_s;
    logic [FIELD_W-1:0]  lo_val_s;
    logic [7:0]          hi_bcd_s;
    logic [7:0]          lo_bcd_s;
    logic                blank_hi_s;
    logic                blank_lo_s;

    // Saturate a field at 99 and split it into {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [FIELD_W-1:0] x);
        logic [6:0] s;
        logic [3:0] tens;
        logic [3:0] ones;
        if (32'(x) > 32'd99) begin
            s = 7'd99;
        end else begin
            s = 7'(x);
        end
        tens = 4'(s / 7'd10);
        ones = 4'(s % 7'd10);
        return {tens, ones};
    endfunction

    assign mode_edge_s = btn_mode & ~mode_prev_r;
    assign edit_edge_s = btn_edit & ~edit_prev_r;
    assign any_edge_s  = mode_edge_s | edit_edge_s;

    // Timeout fires on the tick that would bring the counter to TIMEOUT_S.
    always_comb begin
        timeout_s = 1'b0;
        if ((TIMEOUT_S != 0) && tick1hz && (idle_cnt_r == CNT_TO_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next mode, edit state and commit; mode edge beats edit edge beats timeout.
    always_comb begin
        state_nxt_s  = state_r;
        mode_nxt_s   = mode_r;
        commit_nxt_s = 1'b0;
        if (mode_edge_s) begin
            mode_nxt_s  = (mode_r == MODE_LAST) ? {MODE_W{1'b0}} : (mode_r + MODE_W'(1));
            state_nxt_s = ST_IDLE;
        end else if (edit_edge_s) begin
            case (state_r)
                ST_IDLE:    state_nxt_s = ST_EDIT_HI;
                ST_EDIT_HI: state_nxt_s = ST_EDIT_LO;
                ST_EDIT_LO: begin
                    state_nxt_s  = ST_IDLE;
                    commit_nxt_s = 1'b1;
                end
                default:    state_nxt_s = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            mode_nxt_s  = {MODE_W{1'b0}};
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign entry_s = (state_nxt_s != state_r) && (state_nxt_s != ST_IDLE);

    // Field selection, BCD conversion and blink blanking feeding the digit registers.
    always_comb begin
        hi_val_s   = field_hi[mode_r*FIELD_W +: FIELD_W];
        lo_val_s   = field_lo[mode_r*FIELD_W +: FIELD_W];
        hi_bcd_s   = to_bcd(hi_val_s);
        lo_bcd_s   = to_bcd(lo_val_s);
        blank_hi_s = (state_r == ST_EDIT_HI) && !blink_r;
        blank_lo_s = (state_r == ST_EDIT_LO) && !blink_r;
    end

`ifdef ALERT_BLINK_EN
    logic alert_phase_r;

    // Alert flash phase: toggles on tick2hz while alerted, parked at 1 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            alert_phase_r <= 1'b1;
        end else if (!(|alert)) begin
            alert_phase_r <= 1'b1;
        end else if (tick2hz) begin
            alert_phase_r <= ~alert_phase_r;
        end else begin
            alert_phase_r <= alert_phase_r;
        end
    end

    assign led_nxt_s = (|alert) & alert_phase_r;
`else
    assign led_nxt_s = |alert;
`endif

    // Control state: edge history, mode, edit state and commit pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_prev_r <= 1'b0;
            edit_prev_r <= 1'b0;
            mode_r      <= {MODE_W{1'b0}};
            state_r     <= ST_IDLE;
            commit_r    <= 1'b0;
        end else begin
            mode_prev_r <= btn_mode;
            edit_prev_r <= btn_edit;
            mode_r      <= mode_nxt_s;
            state_r     <= state_nxt_s;
            commit_r    <= commit_nxt_s;
        end
    end

    // Blink phase: re-armed to visible whenever an edit field is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_r <= 1'b1;
        end else if (entry_s) begin
            blink_r <= 1'b1;
        end else if (tick2hz) begin
            blink_r <= ~blink_r;
        end else begin
            blink_r <= blink_r;
        end
    end

    // Idle seconds counter; saturates so a disabled timeout never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (any_edge_s || timeout_s) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (tick1hz && (idle_cnt_r != CNT_MAX)) begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Registered display digits and alert LED.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit3_r <= 4'd0;
            digit2_r <= 4'd0;
            digit1_r <= 4'd0;
            digit0_r <= 4'd0;
            led_r    <= 1'b0;
        end else begin
            digit3_r <= blank_hi_s ? 4'd15 : hi_bcd_s[7:4];
            digit2_r <= blank_hi_s ? 4'd15 : hi_bcd_s[3:0];
            digit1_r <= blank_lo_s ? 4'd15 : lo_bcd_s[7:4];
            digit0_r <= blank_lo_s ? 4'd15 : lo_bcd_s[3:0];
            led_r    <= led_nxt_s;
        end
    end

    assign mode       = mode_r;
    assign edit_field = state_r;
    assign commit     = commit_r;
    assign digit3     = digit3_r;
    assign digit2     = digit2_r;
    assign digit1     = digit1_r;
    assign digit0     = digit0_r;
    assign led        = led_r;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer: directed scenarios followed by
// randomized stimulus, every cycle compared against an event-level model.
module tb_mode_sequencer;

    localparam int N  = 4;
    localparam int TO = 3;
    localparam int FW = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic            tick1hz, tick2hz, btn_mode, btn_edit;
    logic [N*FW-1:0] field_hi, field_lo;
    logic [N-1:0]    alert;
    logic [1:0]      mode;
    logic [1:0]      edit_field;
    logic            commit;
    logic [3:0]      digit3, digit2, digit1, digit0;
    logic            led;

    always #5 clk = ~clk;

    mode_sequencer #(.N_MODES(N), .TIMEOUT_S(TO), .FIELD_W(FW)) dut (
        .clk(clk), .reset(reset), .tick1hz(tick1hz), .tick2hz(tick2hz),
        .btn_mode(btn_mode), .btn_edit(btn_edit),
        .field_hi(field_hi), .field_lo(field_lo), .alert(alert),
        .mode(mode), .edit_field(edit_field), .commit(commit),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .led(led)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: edit is 0 none, 1 hi, 2 lo.
    int m_mode, m_edit, m_cnt, m_blink, m_aph, m_pm, m_pe;
    int e_commit, e_led;
    int e_d[4];

    task automatic split(input int v, output int tens, output int ones);
        int s;
        s = (v > 99) ? 99 : v;
        tens = s / 10;
        ones = s % 10;
    endtask

    task automatic model_update();
        int me, ee, to_hit, old_edit, any_alert, t, o;
        if (reset) begin
            m_mode = 0; m_edit = 0; m_cnt = 0; m_blink = 1; m_aph = 1;
            m_pm = 0; m_pe = 0; e_commit = 0; e_led = 0;
            for (int i = 0; i < 4; i++) e_d[i] = 0;
            return;
        end
        me = (btn_mode && !m_pm) ? 1 : 0;
        ee = (btn_edit && !m_pe) ? 1 : 0;
        to_hit = (tick1hz && (m_cnt + 1 == TO)) ? 1 : 0;
        any_alert = (alert != '0) ? 1 : 0;
        // Display uses the pre-edge mode, edit state and blink phase.
        split(int'(field_hi[m_mode*FW +: FW]), t, o);
        e_d[3] = t; e_d[2] = o;
        split(int'(field_lo[m_mode*FW +: FW]), t, o);
        e_d[1] = t; e_d[0] = o;
        if (m_blink == 0 && m_edit == 1) begin e_d[3] = 15; e_d[2] = 15; end
        if (m_blink == 0 && m_edit == 2) begin e_d[1] = 15; e_d[0] = 15; end
`ifdef ALERT_BLINK_EN
        e_led = any_alert & m_aph;
        if (!any_alert) m_aph = 1;
        else if (tick2hz) m_aph = 1 - m_aph;
`else
        e_led = any_alert;
`endif
        old_edit = m_edit;
        e_commit = (ee && !me && m_edit == 2) ? 1 : 0;
        if (me) begin
            m_mode = (m_mode + 1) % N;
            m_edit = 0;
        end else if (ee) begin
            m_edit = (m_edit + 1) % 3;
        end else if (to_hit) begin
            m_mode = 0;
            m_edit = 0;
        end
        if (me || ee || to_hit) m_cnt = 0;
        else if (tick1hz && m_cnt < 3) m_cnt = m_cnt + 1;
        if (m_edit != 0 && m_edit != old_edit) m_blink = 1;
        else if (tick2hz) m_blink = 1 - m_blink;
        m_pm = btn_mode;
        m_pe = btn_edit;
    endtask

    task automatic compare_all();
        check_val("mode", 32'(mode), 32'(m_mode));
        check_val("edit_field", 32'(edit_field), 32'(m_edit));
        check_val("commit", 32'(commit), 32'(e_commit));
        check_val("digit3", 32'(digit3), 32'(e_d[3]));
        check_val("digit2", 32'(digit2), 32'(e_d[2]));
        check_val("digit1", 32'(digit1), 32'(e_d[1]));
        check_val("digit0", 32'(digit0), 32'(e_d[0]));
        check_val("led", 32'(led), 32'(e_led));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; cycle();
        btn_mode = 1'b0; cycle();
    endtask

    task automatic pulse_edit();
        btn_edit = 1'b1; cycle();
        btn_edit = 1'b0; cycle();
    endtask

    initial begin
        reset = 1'b1; tick1hz = 1'b0; tick2hz = 1'b0;
        btn_mode = 1'b0; btn_edit = 1'b0;
        field_hi = '0; field_lo = '0; alert = '0;
        @(negedge clk);
        cycle(); cycle();
        check_val("reset_mode", 32'(mode), 32'd0);
        check_val("reset_digit3", 32'(digit3), 32'd0);
        reset = 1'b0;
        cycle();

        // Four mode presses walk 1,2,3,0.
        for (int k = 1; k <= 4; k++) begin
            btn_mode = 1'b1; cycle();
            check_val("mode_seq", 32'(mode), 32'(k % 4));
            btn_mode = 1'b0; cycle();
        end

        // Mode 1, fields 12/34, full edit cycle with commit.
        pulse_mode();
        field_hi[1*FW +: FW] = 7'd12;
        field_lo[1*FW +: FW] = 7'd34;
        cycle();
        check_val("dig_12_34", {16'd0, digit3, digit2, digit1, digit0}, 32'h1234);
        btn_edit = 1'b1; cycle();
        check_val("edit_hi", 32'(edit_field), 32'd1);
        btn_edit = 1'b0; cycle();
        btn_edit = 1'b1; cycle();
        check_val("edit_lo", 32'(edit_field), 32'd2);
        btn_edit = 1'b0; cycle();
        check_val("no_commit_yet", 32'(commit), 32'd0);
        btn_edit = 1'b1; cycle();
        check_val("edit_idle", 32'(edit_field), 32'd0);
        check_val("commit_pulse", 32'(commit), 32'd1);
        btn_edit = 1'b0; cycle();
        check_val("commit_drop", 32'(commit), 32'd0);

        // Saturation: 120 shows 99, 7 shows 07.
        field_hi[1*FW +: FW] = 7'd120;
        field_lo[1*FW +: FW] = 7'd7;
        cycle();
        check_val("dig_sat", {16'd0, digit3, digit2, digit1, digit0}, 32'h9907);

        // Timeout from mode 2 mid-edit.
        pulse_mode();
        pulse_edit();
        for (int k = 0; k < 3; k++) begin
            tick1hz = 1'b1; cycle();
            tick1hz = 1'b0; cycle();
        end
        check_val("timeout_mode", 32'(mode), 32'd0);
        check_val("timeout_edit", 32'(edit_field), 32'd0);

        // Edit edge coinciding with the third tick blocks the timeout.
        pulse_mode();
        pulse_mode();
        for (int k = 0; k < 2; k++) begin
            tick1hz = 1'b1; cycle();
            tick1hz = 1'b0; cycle();
        end
        tick1hz = 1'b1; btn_edit = 1'b1; cycle();
        check_val("edge_beats_to", 32'(mode), 32'd2);
        tick1hz = 1'b0; btn_edit = 1'b0; cycle();
        check_val("edge_beats_to_ef", 32'(edit_field), 32'd1);

        // Simultaneous mode and edit edges in EDIT_HI.
        btn_mode = 1'b1; btn_edit = 1'b1; cycle();
        check_val("both_mode", 32'(mode), 32'd3);
        check_val("both_ef", 32'(edit_field), 32'd0);
        check_val("both_commit", 32'(commit), 32'd0);
        btn_mode = 1'b0; btn_edit = 1'b0; cycle();
        check_val("both_commit_after", 32'(commit), 32'd0);

        // Alert on a mode other than the displayed one.
        alert = 4'b0100;
        cycle(); cycle();
        for (int k = 0; k < 4; k++) begin
            tick2hz = 1'b1; cycle();
            tick2hz = 1'b0; cycle();
`ifndef ALERT_BLINK_EN
            check_val("led_steady", 32'(led), 32'd1);
`endif
        end
        alert = 4'b0000;

        // Reset while editing the lo field aborts without commit.
        pulse_edit();
        pulse_edit();
        check_val("pre_reset_ef", 32'(edit_field), 32'd2);
        reset = 1'b1; btn_edit = 1'b1; cycle();
        check_val("rst_ef", 32'(edit_field), 32'd0);
        check_val("rst_commit", 32'(commit), 32'd0);
        check_val("rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000);
        reset = 1'b0; btn_edit = 1'b0; cycle();
        check_val("rst_commit_after", 32'(commit), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 3) == 0) btn_edit = ~btn_edit;
            tick1hz = ($urandom_range(0, 4) == 0);
            tick2hz = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                field_hi = {$urandom, $urandom};
                field_lo = {$urandom, $urandom};
            end
            if ($urandom_range(0, 10) == 0) alert = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 150) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- N_MODES, 4: number of display modes, legal 2..8.
- TIMEOUT_S, 30: idle seconds before auto-return to mode 0; 0 disables the timeout.
- FIELD_W, 7: width of each per-mode field value.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- tick1hz, in, 1: one-cycle pulse at 1 Hz.
- tick2hz, in, 1: one-cycle pulse at 2 Hz.
- btn_mode, in, 1: debounced level, advances the mode.
- btn_edit, in, 1: debounced level, steps the edit state.
- field_hi, in, N_MODES*FIELD_W: left field per mode; mode m occupies bits [m*FIELD_W +: FIELD_W].
- field_lo, in, N_MODES*FIELD_W: right field per mode, same packing.
- alert, in, N_MODES: per-mode alert request.
- mode, out, clog2(N_MODES): current mode index.
- edit_field, out, 2: 00 none, 01 hi field, 10 lo field.
- commit, out, 1: one-cycle pulse when an edit is committed.
- digit3, digit2, digit1, digit0, out, 4 each: BCD digits, left to right; value 15 means blank.
- led, out, 1: alert indicator.

Function
REQ-004 The block SHALL detect rising edges of btn_mode and btn_edit with a registered previous value; a held level SHALL produce exactly one edge.
REQ-005 A btn_mode edge SHALL set mode to (mode+1) mod N_MODES, force the edit state to IDLE, and not assert commit.
REQ-006 The edit FSM SHALL have states IDLE, EDIT_HI and EDIT_LO; each btn_edit edge SHALL step IDLE to EDIT_HI, EDIT_HI to EDIT_LO, and EDIT_LO to IDLE.
REQ-007 The EDIT_LO to IDLE transition SHALL assert commit for exactly the next cycle.
REQ-008 edit_field SHALL be 01 in EDIT_HI, 10 in EDIT_LO, and 00 in IDLE.
REQ-009 If btn_mode and btn_edit edges occur in the same cycle, the mode edge SHALL win and the edit edge SHALL be discarded.
REQ-010 The blink phase SHALL toggle on each tick2hz and SHALL be forced to 1 on entry to EDIT_HI or EDIT_LO.
REQ-011 When the blink phase is 0, digit3 and digit2 SHALL output 15 in EDIT_HI, and digit1 and digit0 SHALL output 15 in EDIT_LO.
REQ-012 Digit conversion SHALL be registered, one cycle latency from the mode and field inputs to the digit outputs:
- digit3 = sat(hi)/10 and digit2 = sat(hi)%10.
- digit1 = sat(lo)/10 and digit0 = sat(lo)%10.
- sat(x) = min(x, 99).
REQ-013 The idle counter SHALL increment on tick1hz and SHALL clear on any button edge.
REQ-014 When the idle counter reaches TIMEOUT_S (with TIMEOUT_S nonzero), the block SHALL set mode to 0, set the edit state to IDLE, clear the counter, and not assert commit.
REQ-015 If a button edge and the timeout occur in the same cycle, the button edge SHALL win and the counter SHALL clear.
REQ-016 The idle counter SHALL saturate and not wrap when TIMEOUT_S is 0.
REQ-017 led SHALL be the OR of all alert bits, independent of the current mode, and SHALL be registered.

Reset
REQ-018 While reset is high at a clock edge, the block SHALL set:
- mode to 0, edit state to IDLE, edit_field to 00, commit to 0;
- all digits to 0, led to 0;
- blink phase to 1, idle counter to 0, edge registers to 0.
REQ-019 Reset asserted mid-edit SHALL abort the edit with no commit pulse.

Configuration
REQ-020 With ALERT_BLINK_EN defined, led SHALL equal (OR of alert) AND an alert phase that toggles on tick2hz and is held at 1 while no alert is active.
REQ-021 Without ALERT_BLINK_EN, led SHALL be the steady OR of alert, and no alert-phase register SHALL exist.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- N_MODES=4, four btn_mode pulses from reset -> mode sequence 1,2,3,0.
- Mode 1 with field_hi=12 and field_lo=34, btn_edit pulsed three times -> edit_field 01,10,00; commit high for exactly one cycle after the third pulse; digits 1,2,3,4 one cycle after the inputs settle.
- field_hi=120 and field_lo=7 -> digits 9,9,0,7.
- TIMEOUT_S=3, mode 2, no buttons for 3 tick1hz pulses -> mode 0 and edit_field 00; a btn_edit edge on the third tick instead -> mode stays 2.
- btn_mode and btn_edit rising in the same cycle in EDIT_HI -> mode+1, edit_field 00, commit 0.
- alert=4'b0100 with ALERT_BLINK_EN defined -> led toggles on each tick2hz; without the macro -> led held at 1; reset asserted in EDIT_LO -> all outputs 0 next cycle, no commit.
